// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// valid/ready bus, hands it to the core and waits for the core's next PC.
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_err,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_NEXT
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_to_cnt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_inst_err;
  logic [31:0] r_fetch_cnt;
  logic        w_take_npc;

  // The core's next PC is only honoured once the current word is consumed.
  assign w_take_npc = npc_valid &&
                      (((r_state == S_OUT) && inst_ready) || (r_state == S_NEXT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= '0;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_inst_err  <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments let the redirect block below override
      // the per-state next-state choice; the last assignment in the block wins.
      unique case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem_req_ready) begin
            r_state  <= S_WAIT;
            r_to_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_inst     <= imem_rsp_data;
            r_inst_err <= imem_rsp_err;
            r_state    <= S_OUT;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
            if (r_to_cnt == TO_LAST) begin
              r_inst     <= '0;
              r_inst_err <= 1'b1;
              r_state    <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (!npc_valid) r_state <= S_NEXT;
          end
        end
        S_NEXT: ;
        default: r_state <= S_IDLE;
      endcase

      // Misaligned targets fault locally without touching the bus.
      if (w_take_npc) begin
        r_pc <= npc;
        if (npc[1:0] == 2'b00) begin
          r_state <= S_REQ;
        end else begin
          r_state    <= S_OUT;
          r_inst     <= '0;
          r_inst_err <= 1'b1;
        end
      end
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign inst_valid     = (r_state == S_OUT);
  assign imem_req_addr  = r_pc;
  assign pc             = r_pc;
  assign inst           = r_inst;
  assign inst_err       = r_inst_err;
  assign fetch_cnt      = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Directed bench for the fetch unit: reset, sequential loop, backpressure,
// misaligned redirect, bus error, timeout and asynchronous reset.
module tb_ysyx_24100005_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        imem_rsp_err   = 1'b0;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_err;
  logic        npc_valid      = 1'b0;
  logic [31:0] npc            = '0;
  logic [31:0] fetch_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_cyc = 0;
  logic [31:0] exp_cnt  = '0;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;

  ysyx_24100005_ifu #(
    .RESET_PC(32'h8000_0000),
    .TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .pc            (pc),
    .inst_err      (inst_err),
    .npc_valid     (npc_valid),
    .npc           (npc),
    .fetch_cnt     (fetch_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({pfx, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({pfx, "_pc"}, pc, 32'h8000_0000);
    check({pfx, "_addr"}, imem_req_addr, 32'h8000_0000);
    check({pfx, "_inst"}, inst, 32'h0);
    check({pfx, "_inst_err"}, 32'(inst_err), 32'd0);
    check({pfx, "_fetch_cnt"}, fetch_cnt, 32'd0);
  endtask

  // Starts in REQ: accept, return the word one cycle later, land in OUT.
  task automatic fetch_one(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic err);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
    check({tag, "_req_addr"}, imem_req_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check({tag, "_wait_req_valid"}, 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_inst"}, inst, data);
    check({tag, "_pc"}, pc, addr);
    check({tag, "_inst_err"}, 32'(inst_err), 32'(err));
  endtask

  task automatic handshake(input logic give_npc, input logic [31:0] next_pc);
    inst_ready = 1'b1;
    npc_valid  = give_npc;
    npc        = next_pc;
    tick();
    inst_ready = 1'b0;
    npc_valid  = 1'b0;
    exp_cnt    = exp_cnt + 32'd1;
    check("handshake_fetch_cnt", fetch_cnt, exp_cnt);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check_reset_values("por");

    tick();
    rst = 1'b1;
    check("idle_req_valid", 32'(imem_req_valid), 32'd0);
    tick();

    // Sequential loop: four words, one every three cycles.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h8000_0000 + 32'(4 * i);
      fetch_one("seq", a, 32'h0000_0413 + 32'(i << 20), 1'b0);
      if (i > 0) check("seq_period", 32'(cyc - last_cyc), 32'd3);
      last_cyc = cyc;
      handshake(1'b1, a + 32'd4);
    end
    check("seq_fetch_cnt", fetch_cnt, 32'd4);

    // Backpressure: five stalled cycles, then three cycles before npc.
    fetch_one("bp", 32'h8000_0010, 32'h0010_0093, 1'b0);
    hold_inst = inst;
    hold_pc   = pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_inst_valid", 32'(inst_valid), 32'd1);
      check("bp_req_valid", 32'(imem_req_valid), 32'd0);
      check("bp_inst_stable", inst, hold_inst);
      check("bp_pc_stable", pc, hold_pc);
    end
    handshake(1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      check("next_inst_valid", 32'(inst_valid), 32'd0);
      check("next_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
    end
    check("next_req_valid_last", 32'(imem_req_valid), 32'd0);
    npc_valid = 1'b1;
    npc       = 32'h8000_0200;
    tick();
    npc_valid = 1'b0;

    // Bus error keeps the returned data.
    fetch_one("buserr", 32'h8000_0200, 32'hCAFE_F00D, 1'b1);

    // Misaligned redirect faults without a request.
    handshake(1'b1, 32'h8000_0102);
    check("mis_req_valid", 32'(imem_req_valid), 32'd0);
    check("mis_inst_valid", 32'(inst_valid), 32'd1);
    check("mis_inst_err", 32'(inst_err), 32'd1);
    check("mis_inst", inst, 32'h0);
    check("mis_pc", pc, 32'h8000_0102);

    // Timeout after four WAIT cycles; a late response is dropped.
    handshake(1'b1, 32'h8000_0300);
    check("to_req_addr", imem_req_addr, 32'h8000_0300);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_wait_inst_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    check("to_inst_valid", 32'(inst_valid), 32'd1);
    check("to_inst_err", 32'(inst_err), 32'd1);
    check("to_inst", inst, 32'h0);
    check("to_pc", pc, 32'h8000_0300);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("late_inst", inst, 32'h0);
    check("late_inst_err", 32'(inst_err), 32'd1);
    check("late_inst_valid", 32'(inst_valid), 32'd1);

    // Response in the last WAIT cycle beats the timeout.
    handshake(1'b1, 32'h8000_0400);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    tick();
    tick();
    check("race_wait_inst_valid", 32'(inst_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    check("race_inst", inst, 32'h0000_0013);
    check("race_inst_err", 32'(inst_err), 32'd0);

    // Asynchronous reset in WAIT, with a stale response pending.
    handshake(1'b1, 32'h8000_0500);
    check("fetch_cnt_before_rst", fetch_cnt, 32'd9);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_values("rst_wait");
    exp_cnt = '0;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    rst = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    check("after_rst_wait_inst", inst, 32'h0);
    fetch_one("restart1", 32'h8000_0000, 32'h0000_0413, 1'b0);
    check("restart1_fetch_cnt", fetch_cnt, 32'd0);

    // Asynchronous reset in OUT.
    #2 rst = 1'b0;
    #1;
    check_reset_values("rst_out");
    tick();
    rst = 1'b1;
    tick();
    fetch_one("restart2", 32'h8000_0000, 32'h0000_0517, 1'b0);
    check("restart2_fetch_cnt", fetch_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
